vehicle_detector: RTL
=====================

VEHICLE_DETECTOR -- requirements
Module: vehicle_detector

Interface
REQ-001 Parameter DEB_CYC, default 4, number of consecutive synchronized samples needed to qualify a sensor edge (legal range 2..255).
REQ-002 Parameter STUCK_CYC, default 1000, number of consecutive occupied-high cycles after which the loop is declared faulty (legal range DEB_CYC+1..65535).
REQ-003 Parameter QW, default 4, width of the waiting-vehicle queue count.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 loop_raw  input  1  raw side-road inductive loop sensor, asynchronous to clk, may bounce.
REQ-007 served  input  1  single-cycle pulse from the traffic light controller: one waiting vehicle has been given side-road green.
REQ-008 veh  output  1  side-road request level, fed to the traffic light controller's vehicle input.
REQ-009 arrive  output  1  single-cycle pulse per qualified vehicle arrival.
REQ-010 qcount  output  QW  number of vehicles waiting.
REQ-011 fault  output  1  sticky loop-stuck indication.

Function
REQ-012 loop_raw shall pass through a 2-flop synchronizer; the second-stage output, s, is the only sensor signal used by the rest of the block.
REQ-013 Presence FSM states: EMPTY, ARMING, OCCUPIED, LEAVING; the FSM shall include an 8-bit debounce counter deb.
REQ-014 EMPTY: s=1 -> ARMING with deb=1; s=0 -> stay.
REQ-015 ARMING: s=0 -> EMPTY (glitch rejected, no arrival); s=1 with deb=DEB_CYC-1 -> OCCUPIED; s=1 otherwise -> deb+1.
REQ-016 Net effect of REQ-014/015: s must be high for DEB_CYC consecutive clk samples to qualify.
REQ-017 arrive shall be high for exactly the one cycle following the ARMING->OCCUPIED transition (registered), and never while fault=1.
REQ-018 OCCUPIED: s=0 -> LEAVING with deb=1; s=1 -> stay.
REQ-019 LEAVING: s=1 -> OCCUPIED (same vehicle, no new arrival); s=0 with deb=DEB_CYC-1 -> EMPTY; s=0 otherwise -> deb+1.
REQ-020 A 16-bit stuck counter shall increment on every cycle with state OCCUPIED and s=1, and clear on any other cycle.
REQ-021 When the stuck counter reaches STUCK_CYC, fault shall be set on the next edge and held until rst.
REQ-022 qcount update per cycle:
- arrive only: +1, saturating at 2^QW-1.
- served only: -1, floored at 0.
- both or neither: unchanged (including at 0 and at saturation).
REQ-023 veh = fault OR (qcount != 0); it is derived only from registers, with no combinational path from loop_raw or served.
REQ-024 Fail-safe: while fault=1, veh shall stay 1, arrive stays 0, served still decrements qcount, and the FSM keeps running.
REQ-025 A served pulse with qcount=0 and no arrive shall be ignored with no error.

Reset
REQ-026 rst=1 shall asynchronously force: synchronizer flops 0, state EMPTY, deb 0, stuck counter 0, qcount 0, arrive 0, fault 0, veh 0.
REQ-027 Reset asserted mid-debounce or mid-occupancy shall discard the partial vehicle; after release a vehicle still present must requalify through EMPTY->ARMING.
REQ-028 Outputs shall be valid from the first clk edge after rst deasserts; no settling cycles.

Verification
REQ-029 DEB_CYC=4: loop_raw high 3 cycles, then low -> arrive never pulses, qcount stays 0, veh stays 0.
REQ-030 DEB_CYC=4: loop_raw held high -> arrive pulses once 2+4 (+1 reg) cycles after the rise, qcount=1, veh=1; a 2-cycle low dip then high again -> no second arrive.
REQ-031 Three clean vehicles, then served pulses 3 times -> qcount 1,2,3 then 2,1,0; veh drops to 0 the cycle after qcount reaches 0.
REQ-032 QW=4: 17 arrivals -> qcount saturates at 15; arrive and served in the same cycle at qcount=15 and at qcount=0 -> qcount unchanged.
REQ-033 STUCK_CYC=20: loop_raw held high -> fault=1 after 20 occupied cycles, veh held 1; further loop toggling gives no arrive; qcount still drains on served; only rst clears fault.
REQ-034 rst pulse during ARMING with loop_raw still high -> all outputs 0; after release, arrive fires only after a full new DEB_CYC qualification.

Source files
------------

// File: rtl/vehicle_detector.sv
// vehicle_detector: synchronizes and debounces a side-road inductive loop,
// turns each qualified vehicle into a one-cycle arrival pulse, and keeps a
// count of vehicles waiting for green. The side-road request is asserted
// whenever vehicles are waiting. A loop that stays occupied for too long is
// latched as a fault, and a fault forces the request on.
module vehicle_detector #(
  parameter int unsigned DEB_CYC   = 4,
  parameter int unsigned STUCK_CYC = 1000,
  parameter int unsigned QW        = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          loop_raw,
  input  logic          served,
  output logic          veh,
  output logic          arrive,
  output logic [QW-1:0] qcount,
  output logic          fault
);

  typedef enum logic [1:0] {
    ST_EMPTY    = 2'd0,
    ST_ARMING   = 2'd1,
    ST_OCCUPIED = 2'd2,
    ST_LEAVING  = 2'd3
  } state_t;

  // The debounce counter counts samples already seen. The decision therefore
  // happens on the sample where the counter equals DEB_CYC-1.
  localparam logic [7:0]    DEB_LAST  = 8'(DEB_CYC - 1);
  localparam logic [15:0]   STUCK_LIM = 16'(STUCK_CYC);
  localparam logic [15:0]   STUCK_MAX = 16'hFFFF;
  localparam logic [QW-1:0] Q_MAX     = {QW{1'b1}};
  localparam logic [QW-1:0] Q_ONE     = QW'(1);

  logic          r_sync1;
  logic          r_sync2;
  logic          w_s;
  state_t        r_state;
  state_t        w_state_nxt;
  logic [7:0]    r_deb;
  logic [7:0]    w_deb_nxt;
  logic          w_qualify;
  logic [15:0]   r_stuck;
  logic          r_fault;
  logic          r_arrive;
  logic [QW-1:0] r_qcount;

  // Two-flop synchronizer. loop_raw is asynchronous to clk.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: every sequential assignment is non-blocking. As a result, r_sync2
    // takes the old value of r_sync1 and not the value just sampled.
    if (rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= loop_raw;
      r_sync2 <= r_sync1;
    end
  end

  assign w_s = r_sync2;

  // Presence FSM state register and debounce counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_EMPTY;
      r_deb   <= 8'd0;
    end else begin
      r_state <= w_state_nxt;
      r_deb   <= w_deb_nxt;
    end
  end

  // Next state. An edge is accepted only after DEB_CYC equal samples in a row.
  always_comb begin
    // NOTE: every output of this block gets a default value first. This covers
    // every path through the case statement, so no latch is inferred.
    w_state_nxt = r_state;
    w_deb_nxt   = r_deb;
    w_qualify   = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_s) begin
          w_state_nxt = ST_ARMING;
          w_deb_nxt   = 8'd1;
        end
      end
      ST_ARMING: begin
        if (!w_s) begin
          w_state_nxt = ST_EMPTY;   // glitch rejected
          w_deb_nxt   = 8'd0;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt = ST_OCCUPIED;
          w_deb_nxt   = 8'd0;
          w_qualify   = 1'b1;
        end else begin
          w_deb_nxt   = r_deb + 8'd1;
        end
      end
      ST_OCCUPIED: begin
        if (!w_s) begin
          w_state_nxt = ST_LEAVING;
          w_deb_nxt   = 8'd1;
        end
      end
      ST_LEAVING: begin
        if (w_s) begin
          w_state_nxt = ST_OCCUPIED; // same vehicle is still on the loop
          w_deb_nxt   = 8'd0;
        end else if (r_deb == DEB_LAST) begin
          w_state_nxt = ST_EMPTY;
          w_deb_nxt   = 8'd0;
        end else begin
          w_deb_nxt   = r_deb + 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_deb_nxt   = 8'd0;
      end
    endcase
  end

  // Length of the current high run while occupied. The counter saturates so
  // that it cannot wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stuck <= 16'd0;
    end else if (r_state == ST_OCCUPIED && w_s) begin
      if (r_stuck != STUCK_MAX) r_stuck <= r_stuck + 16'd1;
    end else begin
      r_stuck <= 16'd0;
    end
  end

  // Sticky fault. It is set one edge after the stuck run reaches its limit and
  // is cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                       r_fault <= 1'b0;
    else if (r_stuck == STUCK_LIM) r_fault <= 1'b1;
  end

  // Registered arrival pulse. It is suppressed once the loop is faulty.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_arrive <= 1'b0;
    else     r_arrive <= w_qualify & ~r_fault;
  end

  // Waiting-vehicle count. It saturates at the top and is floored at zero.
  // An arrival and a service in the same cycle cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_qcount <= '0;
    end else begin
      case ({r_arrive, served})
        2'b10:   if (r_qcount != Q_MAX) r_qcount <= r_qcount + Q_ONE;
        2'b01:   if (r_qcount != '0)    r_qcount <= r_qcount - Q_ONE;
        default: r_qcount <= r_qcount;
      endcase
    end
  end

  assign arrive = r_arrive;
  assign qcount = r_qcount;
  assign fault  = r_fault;
  assign veh    = r_fault | (r_qcount != '0);

endmodule
